// File: rtl/mem_access_pkg.sv
// Shared widths, op codes and MEM-stage state codes for the memory access stage.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package mem_access_pkg;

   localparam int ADDR_LEN     = 32;
   localparam int REG_LEN      = 32;
   localparam int REG_ADDR_LEN = 5;
   localparam int ALU_LEN      = 5;
   localparam int BYTE_LEN     = 8;

   // ALU op codes; anything not listed as a load/store is a pass-through op
   localparam logic [ALU_LEN-1:0] OP_NOP = 5'h00;
   localparam logic [ALU_LEN-1:0] OP_ADD = 5'h01;
   localparam logic [ALU_LEN-1:0] OP_LB  = 5'h10;
   localparam logic [ALU_LEN-1:0] OP_LH  = 5'h11;
   localparam logic [ALU_LEN-1:0] OP_LW  = 5'h12;
   localparam logic [ALU_LEN-1:0] OP_LBU = 5'h13;
   localparam logic [ALU_LEN-1:0] OP_LHU = 5'h14;
   localparam logic [ALU_LEN-1:0] OP_SB  = 5'h15;
   localparam logic [ALU_LEN-1:0] OP_SH  = 5'h16;
   localparam logic [ALU_LEN-1:0] OP_SW  = 5'h17;

   // MEM stage FSM state codes
   localparam logic [1:0] MEM_IDLE = 2'd0;
   localparam logic [1:0] MEM_BUSY = 2'd1;
   localparam logic [1:0] MEM_TAIL = 2'd2;
   localparam logic [1:0] MEM_DONE = 2'd3;

   function automatic logic is_load(input logic [ALU_LEN-1:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [ALU_LEN-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Index of the last byte of the access (access size minus one)
   function automatic logic [1:0] last_idx(input logic [ALU_LEN-1:0] op);
      logic [1:0] idx;
      idx = 2'd0;
      if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) idx = 2'd1;
      if ((op == OP_LW) || (op == OP_SW))                   idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Size/sign extender turning an assembled little-endian word into a load result.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module load_ext
   import mem_access_pkg::*;
(
   input  logic [ALU_LEN-1:0] op,
   input  logic [31:0]        word,
   output logic [REG_LEN-1:0] result
);

   // Select extension by load flavour; LW and unknown ops keep the word as is
   always_comb begin
      result = word;
      case (op)
         OP_LB:   result = {{24{word[7]}}, word[7:0]};
         OP_LH:   result = {{16{word[15]}}, word[15:0]};
         OP_LBU:  result = {24'h000000, word[7:0]};
         OP_LHU:  result = {16'h0000, word[15:0]};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial loads/stores over an 8-bit RAM port, pass-through otherwise.
// Latency: pass-through 0 cycles; loads N+2, stores N+1 cycles from op seen to DONE.
// Backpressure: stall_req holds the upstream pipeline while an access is in flight.
module mem_access
   import mem_access_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ALU_LEN-1:0]      alu_op_i,
   input  logic [ADDR_LEN-1:0]     mem_addr_i,
   input  logic [REG_LEN-1:0]      mem_wdata_i,
   input  logic [REG_LEN-1:0]      rd_data_i,
   input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
   input  logic                    rd_enable_i,
   input  logic [7:0]              ram_din,
   output logic [ADDR_LEN-1:0]     ram_a,
   output logic [7:0]              ram_dout,
   output logic                    ram_wr,
   output logic [REG_LEN-1:0]      rd_data_o,
   output logic [REG_ADDR_LEN-1:0] rd_addr_o,
   output logic                    rd_enable_o,
   output logic                    stall_req
);

   logic [1:0]              state;
   logic [1:0]              cnt;
   logic [ALU_LEN-1:0]      op_q;
   logic [ADDR_LEN-1:0]     addr_q;
   logic [REG_LEN-1:0]      wdata_q;
   logic [31:0]             word_q;
   logic [REG_ADDR_LEN-1:0] rd_addr_q;
   logic                    rd_en_q;
   logic [1:0]              last;
   logic [REG_LEN-1:0]      ext_data;

   assign last = last_idx(op_q);

   load_ext u_load_ext (
      .op     (op_q),
      .word   (word_q),
      .result (ext_data)
   );

   // FSM and access latches; RAM read data lags its address by one cycle,
   // so byte k-1 is captured while address k is presented and TAIL grabs the last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= MEM_IDLE;
         cnt       <= 2'd0;
         op_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         word_q    <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
      end else begin
         case (state)
            MEM_IDLE: begin
               if (is_load(alu_op_i) || is_store(alu_op_i)) begin
                  op_q      <= alu_op_i;
                  addr_q    <= mem_addr_i;
                  wdata_q   <= mem_wdata_i;
                  rd_addr_q <= rd_addr_i;
                  rd_en_q   <= rd_enable_i;
                  word_q    <= '0;
                  cnt       <= 2'd0;
                  state     <= MEM_BUSY;
               end
            end
            MEM_BUSY: begin
               if (is_load(op_q) && (cnt != 2'd0)) begin
                  word_q[{cnt - 2'd1, 3'b000} +: BYTE_LEN] <= ram_din;
               end
               if (cnt == last) begin
                  state <= is_store(op_q) ? MEM_DONE : MEM_TAIL;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            MEM_TAIL: begin
               word_q[{last, 3'b000} +: BYTE_LEN] <= ram_din;
               state <= MEM_DONE;
            end
            default: begin
               state <= MEM_IDLE;
            end
         endcase
      end
   end

   // Output decode; reset forces everything low without waiting for an edge
   always_comb begin
      ram_a       = '0;
      ram_dout    = 8'h00;
      ram_wr      = 1'b0;
      rd_data_o   = '0;
      rd_addr_o   = '0;
      rd_enable_o = 1'b0;
      stall_req   = 1'b0;
      if (!rst) begin
         case (state)
            MEM_IDLE: begin
               if (is_load(alu_op_i) || is_store(alu_op_i)) begin
                  stall_req = 1'b1;
               end else begin
                  rd_data_o   = rd_data_i;
                  rd_addr_o   = rd_addr_i;
                  rd_enable_o = rd_enable_i;
               end
            end
            MEM_BUSY: begin
               stall_req = 1'b1;
               ram_a     = addr_q + {{(ADDR_LEN-2){1'b0}}, cnt};
               if (is_store(op_q)) begin
                  ram_wr   = 1'b1;
                  ram_dout = wdata_q[{cnt, 3'b000} +: BYTE_LEN];
               end
            end
            MEM_TAIL: begin
               stall_req = 1'b1;
            end
            default: begin
               rd_addr_o = rd_addr_q;
               if (is_load(op_q)) begin
                  rd_enable_o = rd_en_q;
                  rd_data_o   = ext_data;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: driver queues expected results/writes, monitor compares.
// Latency: checks result latency in cycles from issue to first stall_req-low cycle.
// Backpressure: driver holds inputs until the monitor has retired the pending op.
module tb_mem_access;
   import mem_access_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [4:0]  addr;
      logic        en;
      int          lat;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [ALU_LEN-1:0]      alu_op_i = OP_NOP;
   logic [ADDR_LEN-1:0]     mem_addr_i = '0;
   logic [REG_LEN-1:0]      mem_wdata_i = '0;
   logic [REG_LEN-1:0]      rd_data_i = '0;
   logic [REG_ADDR_LEN-1:0] rd_addr_i = '0;
   logic                    rd_enable_i = 1'b0;
   logic [7:0]              ram_din = 8'h00;
   logic [ADDR_LEN-1:0]     ram_a;
   logic [7:0]              ram_dout;
   logic                    ram_wr;
   logic [REG_LEN-1:0]      rd_data_o;
   logic [REG_ADDR_LEN-1:0] rd_addr_o;
   logic                    rd_enable_o;
   logic                    stall_req;

   res_t res_q[$];
   wr_t  wr_q[$];
   int   issue_cnt = 0;
   int   done_cnt = 0;
   int   lat = 0;
   int   errors = 0;
   int   checks = 0;
   logic finish_req = 1'b0;
   logic timed_out = 1'b0;
   logic loaded = 1'b0;
   logic [7:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   mem_access dut (
      .clk         (clk),
      .rst         (rst),
      .alu_op_i    (alu_op_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .rd_data_i   (rd_data_i),
      .rd_addr_i   (rd_addr_i),
      .rd_enable_i (rd_enable_i),
      .ram_din     (ram_din),
      .ram_a       (ram_a),
      .ram_dout    (ram_dout),
      .ram_wr      (ram_wr),
      .rd_data_o   (rd_data_o),
      .rd_addr_o   (rd_addr_o),
      .rd_enable_o (rd_enable_o),
      .stall_req   (stall_req)
   );

   // Byte RAM with one-cycle registered read, preloaded on the first edge
   always @(posedge clk) begin
      if (!loaded) begin
         mem[32'h100] = 8'h78; mem[32'h101] = 8'h56;
         mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
         mem[32'h200] = 8'h80;
         mem[32'h210] = 8'h34; mem[32'h211] = 8'h92;
         loaded <= 1'b1;
      end
      if (ram_wr) mem[ram_a] = ram_dout;
      ram_din <= mem.exists(ram_a) ? mem[ram_a] : 8'h00;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: reset zeros, RAM writes, and result retirement with latency
   always @(negedge clk) begin
      if (finish_req) begin
         chk("timeout", {63'd0, timed_out}, 64'd0);
         chk("results_left", 64'(res_q.size()), 64'd0);
         chk("writes_left", 64'(wr_q.size()), 64'd0);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end else if (rst) begin
         chk("reset_outputs", {ram_a, ram_dout, ram_wr, rd_data_o[23:0], rd_addr_o, rd_enable_o, stall_req},
             64'd0);
         chk("reset_rd_hi", {56'd0, rd_data_o[31:24]}, 64'd0);
         if (issue_cnt != done_cnt) begin
            if (res_q.size() > 0) void'(res_q.pop_front());
            done_cnt++;
            lat = 0;
         end
      end else begin
         if (ram_wr) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_write", {24'd0, ram_a, ram_dout}, 64'd0);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("write", {24'd0, ram_a, ram_dout}, {24'd0, w.a, w.d});
            end
         end
         if (issue_cnt != done_cnt) begin
            if (!stall_req) begin
               if (res_q.size() == 0) begin
                  chk("result_unexpected", 64'd1, 64'd0);
               end else begin
                  res_t r;
                  r = res_q.pop_front();
                  chk({r.name, "_data"}, {32'd0, rd_data_o}, {32'd0, r.data});
                  chk({r.name, "_addr"}, {59'd0, rd_addr_o}, {59'd0, r.addr});
                  chk({r.name, "_en"}, {63'd0, rd_enable_o}, {63'd0, r.en});
                  chk({r.name, "_lat"}, 64'(lat), 64'(r.lat));
               end
               done_cnt++;
               lat = 0;
            end else begin
               lat++;
            end
         end
      end
   end

   function automatic int size_of(input logic [4:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   task automatic drive(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] ra, input logic en);
      alu_op_i    = op;
      mem_addr_i  = addr;
      mem_wdata_i = wdata;
      rd_data_i   = rdata;
      rd_addr_i   = ra;
      rd_enable_i = en;
      issue_cnt++;
   endtask

   // Issue one op (called just after a rising edge) and hold it until retired
   task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] ra,
                        input logic en, input logic [31:0] exp_d, input logic exp_en);
      int   n;
      int   el;
      logic [31:0] wb;
      n  = size_of(op);
      el = 0;
      if (op == OP_SB || op == OP_SH || op == OP_SW) begin
         el = n + 1;
         wb = wdata;
         for (int k = 0; k < n; k++) wr_q.push_back('{addr + k, wb[8*k +: 8]});
      end else if (n != 0) begin
         el = n + 2;
      end
      res_q.push_back('{name, exp_d, ra, exp_en, el});
      drive(op, addr, wdata, rdata, ra, en);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (done_cnt == issue_cnt) break;
      end
      if (done_cnt != issue_cnt) timed_out = 1'b1;
      #1;
   endtask

   // Start an access, then assert reset two cycles later (in its T2)
   task automatic reset_mid(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] wb;
      wb = wdata;
      if (op == OP_SB || op == OP_SH || op == OP_SW) wr_q.push_back('{addr, wb[7:0]});
      res_q.push_back('{"aborted", 32'd0, 5'd0, 1'b0, 0});
      drive(op, addr, wdata, 32'd0, 5'd1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      alu_op_i = OP_NOP;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Reset with a load on the inputs: outputs must stay at zero
      alu_op_i  = OP_LW;
      rd_data_i = 32'h5A5A5A5A;
      rd_addr_i = 5'd3;
      repeat (3) @(posedge clk);
      #1;
      alu_op_i = OP_NOP;
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_op("add",  OP_ADD,  32'h0,        32'h0,        32'h00000007, 5'd5,  1'b1, 32'h00000007, 1'b1);
      do_op("illeg", 5'h1F,  32'h100,      32'h0,        32'hCAFEF00D, 5'd9,  1'b1, 32'hCAFEF00D, 1'b1);
      do_op("lw",   OP_LW,   32'h100,      32'h0,        32'h0,        5'd3,  1'b1, 32'h12345678, 1'b1);
      do_op("lb",   OP_LB,   32'h200,      32'h0,        32'h0,        5'd4,  1'b1, 32'hFFFFFF80, 1'b1);
      do_op("lbu",  OP_LBU,  32'h200,      32'h0,        32'h0,        5'd4,  1'b1, 32'h00000080, 1'b1);
      do_op("lh",   OP_LH,   32'h210,      32'h0,        32'h0,        5'd6,  1'b1, 32'hFFFF9234, 1'b1);
      do_op("lhu",  OP_LHU,  32'h210,      32'h0,        32'h0,        5'd6,  1'b1, 32'h00009234, 1'b1);
      do_op("lw_noen", OP_LW, 32'h100,     32'h0,        32'h0,        5'd10, 1'b0, 32'h12345678, 1'b0);
      do_op("sw",   OP_SW,   32'h300,      32'hDEADBEEF, 32'h0,        5'd7,  1'b1, 32'h00000000, 1'b0);
      do_op("sh_wrap", OP_SH, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0,       5'd8,  1'b1, 32'h00000000, 1'b0);
      do_op("lw_rb", OP_LW,  32'h300,      32'h0,        32'h0,        5'd11, 1'b1, 32'hDEADBEEF, 1'b1);
      do_op("lh_wrap", OP_LH, 32'hFFFFFFFF, 32'h0,       32'h0,        5'd12, 1'b1, 32'hFFFFABCD, 1'b1);

      reset_mid(OP_LW, 32'h100, 32'h0);
      do_op("lw_after_rst", OP_LW, 32'h100, 32'h0,       32'h0,        5'd13, 1'b1, 32'h12345678, 1'b1);
      reset_mid(OP_SW, 32'h400, 32'h11223344);
      do_op("lbu_part0", OP_LBU, 32'h400,  32'h0,        32'h0,        5'd14, 1'b1, 32'h00000044, 1'b1);
      do_op("lbu_part1", OP_LBU, 32'h401,  32'h0,        32'h0,        5'd14, 1'b1, 32'h00000000, 1'b1);

      do_op("b2b_lw", OP_LW, 32'h100,      32'h0,        32'h0,        5'd15, 1'b1, 32'h12345678, 1'b1);
      do_op("b2b_sb", OP_SB, 32'h500,      32'h00000055, 32'h0,        5'd16, 1'b1, 32'h00000000, 1'b0);
      do_op("sb_rb", OP_LBU, 32'h500,      32'h0,        32'h0,        5'd17, 1'b1, 32'h00000055, 1'b1);

      alu_op_i = OP_NOP;
      rd_enable_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      finish_req = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL finish: monitor did not end the run");
      $fatal(1);
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RISC-V pipeline, fed by ex_mem with the EX results: alu_op, effective address, store data and rd data.
- Performs loads and stores over the byte-wide data RAM port, one byte per cycle, little-endian.
- Sign- or zero-extends load results and passes non-memory results through to mem_wb and to id forwarding.
- Holds the pipeline through ctrl with stall_req while an access is in flight.

Parameters:
- None. All widths come from config.vh: `AddrLen, `RegLen, `RegAddrLen, `ALU_Len.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high (`ResetEnable)
- alu_op_i  in  `ALU_Len  op from ex_mem (`LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW, others pass through)
- mem_addr_i  in  `AddrLen  effective address
- mem_wdata_i  in  `RegLen  store data (reg2)
- rd_data_i  in  `RegLen  EX result for non-memory ops
- rd_addr_i  in  `RegAddrLen  destination register
- rd_enable_i  in  1  destination write enable
- ram_din  in  8  RAM read byte; valid one cycle after its address
- ram_a  out  `AddrLen  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_wr  out  1  RAM write strobe (1 = write)
- rd_data_o  out  `RegLen  result to mem_wb / id forwarding
- rd_addr_o  out  `RegAddrLen  destination to mem_wb / id
- rd_enable_o  out  1  write enable to mem_wb / id
- stall_req  out  1  to ctrl; freezes pc_reg, if_id, id_ex, ex_mem while 1

Behaviour:
- Reset, asynchronous:
  - state=IDLE, cnt=0, all latches 0.
  - ram_a=0, ram_dout=0, ram_wr=0, stall_req=0.
  - rd_data_o=0, rd_addr_o=0, rd_enable_o=0.
- Access size N from op: 1 for B/BU, 2 for H/HU, 4 for W.
- FSM states: IDLE, BUSY, TAIL, DONE.
- IDLE:
  - Non-memory op: combinational pass-through of rd_data_i, rd_addr_i, rd_enable_i; stall_req=0.
  - Memory op: stall_req=1 in the same cycle (combinational).
  - At the clock edge: latch op, addr, wdata, rd_addr, rd_enable; clear assembly register; cnt=0; go to BUSY.
- BUSY, cnt=k:
  - ram_a = latched addr + k, mod 2^32 (0xFFFFFFFF wraps to 0x00000000). No alignment requirement.
  - Store: ram_wr=1, ram_dout = wdata[8k+7:8k].
  - Load: ram_wr=0; for k>=1, capture ram_din into byte k-1.
  - If k=N-1: store goes to DONE, load goes to TAIL. Otherwise cnt+1.
  - stall_req=1.
- TAIL (loads only): ram_wr=0; capture ram_din into byte N-1; stall_req=1; go to DONE.
- DONE: stall_req=0; the pipeline advances at this edge; next state is IDLE unconditionally. Inputs are ignored in DONE.
- Outputs in DONE:
  - rd_addr_o = latched rd_addr; rd_enable_o = latched enable for loads, 0 for stores.
  - rd_data_o: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW uses the word as assembled; stores give 0.
- Latency, op-seen cycle T0 to DONE:
  - Loads: N+2 cycles (LW: DONE at T6; stall_req high T0..T5).
  - Stores: N+1 cycles (SW: DONE at T5; stall_req high T0..T4).
- Outside IDLE and DONE: rd_enable_o=0, so id does not forward a stale value.
- ram_wr is 1 only in BUSY with a store op, never in any other state or cycle.
- Memory op arriving in the cycle after DONE: handled from IDLE normally; one dead cycle between back-to-back accesses is accepted.
- Reset mid-operation: immediate return to IDLE; ram_wr and stall_req drop asynchronously; a partial store is not completed or rolled back.
- Illegal or unknown alu_op: treated as pass-through.

Decomposition:
- config.vh already holds the op codes and widths. Add `MemIdle/`MemBusy/`MemTail/`MemDone state codes there, plus a `ByteLen 8 constant.
- One sub-module is natural: load_ext, a combinational size/sign extender (op, 32-bit assembled word -> `RegLen result). It is reused by any later cache path.

Test Plan:
- ADD, rd_data_i=0x00000007, rd_addr_i=5 -> same-cycle rd_data_o=0x7, rd_addr_o=5, stall_req=0, ram_wr never 1.
- LW at 0x100, RAM bytes 78 56 34 12 -> ram_a 0x100..0x103 on T1..T4; stall_req high T0..T5; DONE T6 with rd_data_o=0x12345678.
- LB / LBU at 0x200, byte 0x80 -> 0xFFFFFF80 / 0x00000080. LH at 0x210, bytes 34 92 -> 0xFFFF9234; LHU -> 0x00009234.
- SW 0xDEADBEEF at 0x300 -> ram_wr=1 on T1..T4 with EF,BE,AD,DE at 0x300..0x303; stall_req low at T5; rd_enable_o=0.
- SH 0xABCD at 0xFFFFFFFF -> writes CD at 0xFFFFFFFF, then AB at 0x00000000.
- Reset asserted at T2 of LW -> ram_wr=0, stall_req=0, all outputs 0 without waiting for a clock edge; the next op starts from IDLE. Back-to-back LW then SB -> both complete correctly with one dead cycle between.
